// File: rtl/fetch_stage.sv
// Instruction fetch stage with the IF/ID pipeline register: owns the PC, drives the
// I-cache port, applies decode redirects, stalls on misses/hazards and freezes on HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        branch_en,
  input  logic [15:0] branch_target,
  input  logic        flush,
  input  logic        i_cache_stall,
  input  logic [15:0] imem_instr,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  output logic [15:0] IFID_instr,
  output logic [15:0] IFID_PC_two,
  output logic        IFID_valid,
  output logic [15:0] pc_out,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_WAIT = 2'd1,
    HALTED    = 2'd2
  } state_t;

  state_t      state_reg;
  logic [15:0] pc_reg;
  logic [15:0] ifid_instr_reg;
  logic [15:0] ifid_pc_two_reg;
  logic        ifid_valid_reg;
  logic        halted_reg;
  logic        imem_req_reg;
  logic        pend_valid_reg;
  logic [15:0] pend_target_reg;

  logic [15:0] pc_plus_two;
  logic        is_hlt;

  assign pc_plus_two = pc_reg + 16'd2;
  assign is_hlt      = (imem_instr[15:12] == HLT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      ifid_instr_reg  <= NOP_INSTR;
      ifid_pc_two_reg <= 16'h0000;
      ifid_valid_reg  <= 1'b0;
      halted_reg      <= 1'b0;
      imem_req_reg    <= 1'b1;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= 16'h0000;
    end else if (state_reg == HALTED) begin
      // Frozen until reset; the HLT drains out of IF/ID once decode stops stalling.
      if (!hazard_stall) begin
        ifid_instr_reg <= NOP_INSTR;
        ifid_valid_reg <= 1'b0;
      end
    end else if (branch_en) begin
      ifid_instr_reg <= NOP_INSTR;
      ifid_valid_reg <= 1'b0;
      if (i_cache_stall) begin
        // Cannot abandon the outstanding miss; remember where to go once it resolves.
        pend_valid_reg  <= 1'b1;
        pend_target_reg <= branch_target;
        state_reg       <= MISS_WAIT;
      end else begin
        pc_reg         <= branch_target;
        pend_valid_reg <= 1'b0;
        state_reg      <= RUN;
      end
    end else if (i_cache_stall) begin
      state_reg <= MISS_WAIT;
      if (!hazard_stall) begin
        ifid_instr_reg <= NOP_INSTR;
        ifid_valid_reg <= 1'b0;
      end
    end else if (state_reg == MISS_WAIT && pend_valid_reg) begin
      // Returned word belongs to the squashed path.
      pc_reg         <= pend_target_reg;
      ifid_instr_reg <= NOP_INSTR;
      ifid_valid_reg <= 1'b0;
      pend_valid_reg <= 1'b0;
      state_reg      <= RUN;
    end else if (hazard_stall) begin
      state_reg <= RUN;
    end else if (flush) begin
      pc_reg         <= pc_plus_two;
      ifid_instr_reg <= NOP_INSTR;
      ifid_valid_reg <= 1'b0;
      state_reg      <= RUN;
    end else begin
      ifid_instr_reg  <= imem_instr;
      ifid_pc_two_reg <= pc_plus_two;
      ifid_valid_reg  <= 1'b1;
      if (is_hlt) begin
        state_reg    <= HALTED;
        halted_reg   <= 1'b1;
        imem_req_reg <= 1'b0;
      end else begin
        pc_reg    <= pc_plus_two;
        state_reg <= RUN;
      end
    end
  end

  assign imem_addr   = pc_reg;
  assign imem_req    = imem_req_reg;
  assign IFID_instr  = ifid_instr_reg;
  assign IFID_PC_two = ifid_pc_two_reg;
  assign IFID_valid  = ifid_valid_reg;
  assign pc_out      = pc_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: a combinational instruction memory
// answers the fetch port and every IF/ID, PC and status output is checked.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_stall;
  logic        branch_en;
  logic [15:0] branch_target;
  logic        flush;
  logic        i_cache_stall;
  logic [15:0] imem_instr;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] IFID_instr;
  logic [15:0] IFID_PC_two;
  logic        IFID_valid;
  logic [15:0] pc_out;
  logic        halted;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .hazard_stall  (hazard_stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .flush         (flush),
    .i_cache_stall (i_cache_stall),
    .imem_instr    (imem_instr),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .IFID_instr    (IFID_instr),
    .IFID_PC_two   (IFID_PC_two),
    .IFID_valid    (IFID_valid),
    .pc_out        (pc_out),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Program image: a few fixed words, everything else 3xxx (never an HLT).
  always_comb begin
    case (imem_addr)
      16'h0000: imem_instr = 16'h1123;
      16'h0002: imem_instr = 16'h2456;
      16'h0050: imem_instr = 16'hF000;
      16'h0060: imem_instr = 16'h8A12;
      default:  imem_instr = {4'h3, imem_addr[11:0]};
    endcase
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [15:0] target);
    branch_en     = 1'b1;
    branch_target = target;
    step();
    branch_en     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hazard_stall = 1'b0; branch_en = 1'b0; branch_target = 16'h0000;
    flush = 1'b0; i_cache_stall = 1'b0;
    step(); step();
    check("rst_pc", pc_out, 16'h0000);
    check("rst_valid", {15'd0, IFID_valid}, 16'd0);
    check("rst_instr", IFID_instr, 16'h0000);
    check("rst_pc_two", IFID_PC_two, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_req", {15'd0, imem_req}, 16'd1);
    rst = 1'b0;

    // Straight-line fetch
    step();
    check("seq1_instr", IFID_instr, 16'h1123);
    check("seq1_pc_two", IFID_PC_two, 16'h0002);
    check("seq1_pc", pc_out, 16'h0002);
    step();
    check("seq2_instr", IFID_instr, 16'h2456);
    check("seq2_pc_two", IFID_PC_two, 16'h0004);
    check("seq2_pc", pc_out, 16'h0004);

    // Taken branch 0010 -> 0040
    jump(16'h0010);
    check("pre_br_pc", pc_out, 16'h0010);
    jump(16'h0040);
    check("br_bubble", {15'd0, IFID_valid}, 16'd0);
    check("br_pc", pc_out, 16'h0040);
    step();
    check("br_instr", IFID_instr, 16'h3040);
    check("br_pc_two", IFID_PC_two, 16'h0042);
    check("br_valid", {15'd0, IFID_valid}, 16'd1);

    // Three-cycle miss at 0020
    jump(16'h0020);
    i_cache_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("miss_pc_%0d", i), pc_out, 16'h0020);
      check($sformatf("miss_bubble_%0d", i), {15'd0, IFID_valid}, 16'd0);
    end
    i_cache_stall = 1'b0;
    step();
    check("miss_instr", IFID_instr, 16'h3020);
    check("miss_pc_two", IFID_PC_two, 16'h0022);
    check("miss_pc", pc_out, 16'h0022);

    // Redirect arriving during a miss
    jump(16'h0030);
    i_cache_stall = 1'b1;
    step();
    branch_en = 1'b1; branch_target = 16'h0100;
    step();
    check("pend_pc_hold", pc_out, 16'h0030);
    check("pend_bubble", {15'd0, IFID_valid}, 16'd0);
    branch_en = 1'b0; i_cache_stall = 1'b0;
    step();
    check("pend_pc", pc_out, 16'h0100);
    check("pend_discard", {15'd0, IFID_valid}, 16'd0);
    step();
    check("pend_instr", IFID_instr, 16'h3100);
    check("pend_pc_two", IFID_PC_two, 16'h0102);

    // Hazard hold with 8A12 in IF/ID
    jump(16'h0060);
    step();
    check("hz_load", IFID_instr, 16'h8A12);
    hazard_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("hz_instr_%0d", i), IFID_instr, 16'h8A12);
      check($sformatf("hz_pc_%0d", i), pc_out, 16'h0062);
    end
    hazard_stall = 1'b0;
    step();
    check("hz_release_instr", IFID_instr, 16'h3062);
    check("hz_release_pc_two", IFID_PC_two, 16'h0064);

    // Flush drops the fetched word but still advances
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_bubble", {15'd0, IFID_valid}, 16'd0);
    check("flush_pc", pc_out, 16'h0066);

    // PC wrap
    jump(16'hFFFE);
    step();
    check("wrap_pc", pc_out, 16'h0000);
    check("wrap_instr", IFID_instr, 16'h3FFE);
    check("wrap_pc_two", IFID_PC_two, 16'h0000);

    // HLT at 0050
    jump(16'h0050);
    step();
    check("hlt_instr", IFID_instr, 16'hF000);
    check("hlt_pc", pc_out, 16'h0050);
    check("hlt_halted", {15'd0, halted}, 16'd1);
    check("hlt_req", {15'd0, imem_req}, 16'd0);
    step();
    check("hlt_drain", {15'd0, IFID_valid}, 16'd0);
    jump(16'h0200);
    check("hlt_ignore_br", pc_out, 16'h0050);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_pc", pc_out, 16'h0000);
    check("post_rst_halted", {15'd0, halted}, 16'd0);
    check("post_rst_req", {15'd0, imem_req}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
